// File: rtl/glitcher_pkg.sv
// Shared definitions for the glitcher trigger path.
// Contents:
//   EDGE_RISE / EDGE_FALL / EDGE_ANY  edge_sel encodings (2 bits; 2'b11 also means "any")
//   trig_state_t                      trigger conditioner FSM states
//   edge_qualify()                    picks the qualifying edge for a given selection
package glitcher_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_ANY  = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } trig_state_t;

  // Both 2'b10 and 2'b11 select either edge, so only the low encodings are special.
  function automatic logic edge_qualify(input logic [1:0] sel,
                                        input logic       rise,
                                        input logic       fall);
    logic q;
    q = rise | fall;
    if (sel == EDGE_RISE) q = rise;
    else if (sel == EDGE_FALL) q = fall;
    return q;
  endfunction

endpackage

// File: rtl/trigger_conditioner_sync_filter.sv
// sync_filter: synchroniser plus glitch filter for one asynchronous input.
// A new level on the synchronised input must persist for len_i extra cycles
// before it is accepted onto q_o; len_i = 0 passes it through one cycle later.
// Ports:
//   clk    in  1       system clock
//   rst_n  in  1       asynchronous reset, active low
//   d_i    in  1       raw asynchronous input
//   len_i  in  FILT_W  extra stable cycles required before a level change is accepted
//   q_o    out 1       filtered, clk-aligned level
module sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_i,
  input  logic [FILT_W-1:0] len_i,
  output logic              q_o
);

  localparam logic [FILT_W-1:0] MCNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  logic                   filt;
  logic [FILT_W-1:0]      mcnt;

  // Plain shift-register synchroniser; the last stage is the first usable copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d_i};
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  // Count how long the synchronised level has disagreed with the accepted level.
  // The >= guards against len_i dropping below a count already in progress,
  // which would otherwise leave the counter parked at saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b0;
      mcnt <= '0;
    end else if (sync_q == filt) begin
      mcnt <= '0;
    end else if (mcnt >= len_i) begin
      filt <= sync_q;
      mcnt <= '0;
    end else if (mcnt != MCNT_MAX) begin
      mcnt <= mcnt + 1'b1;
    end
  end

  assign q_o = filt;

endmodule

// File: rtl/trigger_conditioner.sv
// trigger_conditioner: front-end for the glitch controller's trigger input.
// Synchronises and deglitches the raw trigger pin, detects the selected edge
// and, once armed, emits one clk-wide pulse on the Nth qualifying edge.
// Each arm yields at most one pulse.
// Ports:
//   clk           in  1       system clock
//   rst_n         in  1       asynchronous reset, active low
//   trigger_i     in  1       raw asynchronous trigger pin
//   arm_i         in  1       pulse: latch config and enter ARMED
//   disarm_i      in  1       pulse: abort and return to IDLE
//   edge_sel_i    in  2       00 rising, 01 falling, 1x either edge
//   filter_len_i  in  FILT_W  glitch filter length, latched at arm
//   edge_count_i  in  CNT_W   qualifying edges to fire on (0 behaves as 1)
//   trig_o        out 1       single-cycle trigger pulse
//   armed_o       out 1       high while ARMED
//   edges_left_o  out CNT_W   edges remaining before fire (0 in IDLE)
module trigger_conditioner
  import glitcher_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger_i,
  input  logic              arm_i,
  input  logic              disarm_i,
  input  logic [1:0]        edge_sel_i,
  input  logic [FILT_W-1:0] filter_len_i,
  input  logic [CNT_W-1:0]  edge_count_i,
  output logic              trig_o,
  output logic              armed_o,
  output logic [CNT_W-1:0]  edges_left_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  trig_state_t       state;
  logic [1:0]        sel_q;
  logic [FILT_W-1:0] filt_len_q;
  logic [CNT_W-1:0]  edges_left;
  logic              filt;
  logic              filt_d;
  logic              rise;
  logic              fall;
  logic              qual;

  sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_W     (FILT_W)
  ) u_sync_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (trigger_i),
    .len_i(filt_len_q),
    .q_o  (filt)
  );

  // Delayed copy of the filtered level for edge detection. It runs in every
  // state, so a level already present at arm time never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_d <= 1'b0;
    end else begin
      filt_d <= filt;
    end
  end

  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;
  assign qual = edge_qualify(sel_q, rise, fall);

  // One-shot FSM. Config is latched only on the IDLE->ARMED transition, so
  // the edge present in the arm cycle is not counted. Disarm outranks a
  // qualifying edge arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel_q      <= EDGE_RISE;
      filt_len_q <= '0;
      edges_left <= '0;
      trig_o     <= 1'b0;
      armed_o    <= 1'b0;
    end else begin
      trig_o <= 1'b0;
      case (state)
        IDLE: begin
          if (arm_i && !disarm_i) begin
            state      <= ARMED;
            armed_o    <= 1'b1;
            sel_q      <= edge_sel_i;
            filt_len_q <= filter_len_i;
            edges_left <= (edge_count_i == '0) ? CNT_ONE : edge_count_i;
          end
        end
        ARMED: begin
          if (disarm_i) begin
            state      <= IDLE;
            armed_o    <= 1'b0;
            edges_left <= '0;
          end else if (qual) begin
            if (edges_left > CNT_ONE) begin
              edges_left <= edges_left - CNT_ONE;
            end else begin
              state      <= IDLE;
              armed_o    <= 1'b0;
              trig_o     <= 1'b1;
              edges_left <= '0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          armed_o    <= 1'b0;
          edges_left <= '0;
        end
      endcase
    end
  end

  assign edges_left_o = edges_left;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed self-checking bench for trigger_conditioner (default parameters).
// Inputs change 1 ns after a rising edge and outputs are sampled there too,
// so "edge N" below counts rising edges after the one that precedes a change.
module tb_trigger_conditioner;

  localparam int FILT_W = 8;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              trigger_i;
  logic              arm_i;
  logic              disarm_i;
  logic [1:0]        edge_sel_i;
  logic [FILT_W-1:0] filter_len_i;
  logic [CNT_W-1:0]  edge_count_i;
  logic              trig_o;
  logic              armed_o;
  logic [CNT_W-1:0]  edges_left_o;

  int total;
  int bad;
  int pulses;

  trigger_conditioner #(
    .SYNC_STAGES(2),
    .FILT_W     (FILT_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trigger_i   (trigger_i),
    .arm_i       (arm_i),
    .disarm_i    (disarm_i),
    .edge_sel_i  (edge_sel_i),
    .filter_len_i(filter_len_i),
    .edge_count_i(edge_count_i),
    .trig_o      (trig_o),
    .armed_o     (armed_o),
    .edges_left_o(edges_left_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present an arm request with the given config for exactly one edge.
  task automatic applyStimulus(input logic [1:0] sel, input logic [FILT_W-1:0] len,
                               input logic [CNT_W-1:0] cnt);
    edge_sel_i   = sel;
    filter_len_i = len;
    edge_count_i = cnt;
    arm_i        = 1'b1;
    tick(1);
    arm_i        = 1'b0;
  endtask

  // Run n cycles and count trig_o pulses seen.
  task automatic countPulses(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick(1);
      if (trig_o) cnt++;
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    trigger_i    = 1'b0;
    arm_i        = 1'b0;
    disarm_i     = 1'b0;
    edge_sel_i   = 2'b00;
    filter_len_i = '0;
    edge_count_i = '0;

    // Reset state
    tick(3);
    checkOutput("rst_trig", 32'(trig_o), 0);
    checkOutput("rst_armed", 32'(armed_o), 0);
    checkOutput("rst_left", 32'(edges_left_o), 0);
    rst_n = 1'b1;
    tick(2);

    // 1: len 0, rise, count 1 -> pulse at edge 4
    $display("[TB] test 1: passthrough rising edge");
    applyStimulus(2'b00, 8'd0, 16'd1);
    checkOutput("t1_armed", 32'(armed_o), 1);
    checkOutput("t1_left", 32'(edges_left_o), 1);
    trigger_i = 1'b1;
    tick(3);
    checkOutput("t1_trig_e3", 32'(trig_o), 0);
    tick(1);
    checkOutput("t1_trig_e4", 32'(trig_o), 1);
    checkOutput("t1_armed_e4", 32'(armed_o), 0);
    checkOutput("t1_left_e4", 32'(edges_left_o), 0);
    tick(1);
    checkOutput("t1_trig_e5", 32'(trig_o), 0);
    trigger_i = 1'b0;
    tick(10);

    // 2: len 3 latched at arm (live input changed afterwards)
    $display("[TB] test 2: glitch filter length 3");
    applyStimulus(2'b00, 8'd3, 16'd1);
    filter_len_i = 8'd0;
    trigger_i = 1'b1;
    tick(2);
    trigger_i = 1'b0;
    countPulses(15, pulses);
    checkOutput("t2_glitch_pulses", 32'(pulses), 0);
    checkOutput("t2_glitch_armed", 32'(armed_o), 1);
    trigger_i = 1'b1;
    tick(6);
    checkOutput("t2_trig_e6", 32'(trig_o), 0);
    trigger_i = 1'b0;
    tick(1);
    checkOutput("t2_trig_e7", 32'(trig_o), 1);
    checkOutput("t2_armed_e7", 32'(armed_o), 0);
    tick(20);

    // 3: count 3, either edge
    $display("[TB] test 3: count 3 on either edge");
    applyStimulus(2'b10, 8'd0, 16'd3);
    checkOutput("t3_left0", 32'(edges_left_o), 3);
    trigger_i = 1'b1;
    countPulses(20, pulses);
    checkOutput("t3_left1", 32'(edges_left_o), 2);
    checkOutput("t3_pulses1", 32'(pulses), 0);
    trigger_i = 1'b0;
    countPulses(20, pulses);
    checkOutput("t3_left2", 32'(edges_left_o), 1);
    checkOutput("t3_pulses2", 32'(pulses), 0);
    trigger_i = 1'b1;
    countPulses(20, pulses);
    checkOutput("t3_pulses3", 32'(pulses), 1);
    checkOutput("t3_left3", 32'(edges_left_o), 0);
    checkOutput("t3_armed3", 32'(armed_o), 0);
    trigger_i = 1'b0;
    countPulses(20, pulses);
    checkOutput("t3_pulses4", 32'(pulses), 0);

    // 4: fall, count 0 treated as 1, pin already high at arm
    $display("[TB] test 4: falling edge with count 0");
    trigger_i = 1'b1;
    tick(10);
    applyStimulus(2'b01, 8'd0, 16'd0);
    checkOutput("t4_left", 32'(edges_left_o), 1);
    countPulses(10, pulses);
    checkOutput("t4_hold_pulses", 32'(pulses), 0);
    trigger_i = 1'b0;
    countPulses(10, pulses);
    checkOutput("t4_fall_pulses", 32'(pulses), 1);
    trigger_i = 1'b1;
    tick(10);
    applyStimulus(2'b00, 8'd0, 16'd1);
    countPulses(20, pulses);
    checkOutput("t4_high_rise_pulses", 32'(pulses), 0);
    checkOutput("t4_high_rise_armed", 32'(armed_o), 1);
    disarm_i = 1'b1;
    tick(1);
    disarm_i = 1'b0;
    checkOutput("t4_disarm_armed", 32'(armed_o), 0);
    checkOutput("t4_disarm_left", 32'(edges_left_o), 0);
    trigger_i = 1'b0;
    tick(10);

    // 5: disarm collides with the qualifying edge, then arm while ARMED
    $display("[TB] test 5: disarm priority and re-arm ignore");
    applyStimulus(2'b00, 8'd0, 16'd1);
    trigger_i = 1'b1;
    tick(3);
    disarm_i = 1'b1;
    tick(1);
    disarm_i = 1'b0;
    checkOutput("t5_collide_trig", 32'(trig_o), 0);
    checkOutput("t5_collide_armed", 32'(armed_o), 0);
    countPulses(10, pulses);
    checkOutput("t5_collide_pulses", 32'(pulses), 0);
    trigger_i = 1'b0;
    tick(10);
    applyStimulus(2'b00, 8'd0, 16'd3);
    trigger_i = 1'b1;
    tick(10);
    checkOutput("t5_left_after_rise", 32'(edges_left_o), 2);
    trigger_i = 1'b0;
    tick(10);
    checkOutput("t5_left_after_fall", 32'(edges_left_o), 2);
    applyStimulus(2'b01, 8'd0, 16'd5);
    checkOutput("t5_rearm_left", 32'(edges_left_o), 2);
    checkOutput("t5_rearm_armed", 32'(armed_o), 1);

    // 6: asynchronous reset while ARMED with 2 edges left
    $display("[TB] test 6: async reset mid-operation");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_armed", 32'(armed_o), 0);
    checkOutput("t6_async_left", 32'(edges_left_o), 0);
    checkOutput("t6_async_trig", 32'(trig_o), 0);
    tick(3);
    rst_n = 1'b1;
    countPulses(5, pulses);
    checkOutput("t6_release_pulses", 32'(pulses), 0);
    trigger_i = 1'b1;
    countPulses(10, pulses);
    checkOutput("t6_unarmed_pulses", 32'(pulses), 0);
    checkOutput("t6_unarmed_armed", 32'(armed_o), 0);
    trigger_i = 1'b0;
    tick(10);
    applyStimulus(2'b00, 8'd0, 16'd1);
    trigger_i = 1'b1;
    countPulses(10, pulses);
    checkOutput("t6_rearmed_pulses", 32'(pulses), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
